// File: rtl/weighted_rr_scheduler.sv
// Weighted round-robin scheduler.
// The owner keeps the grant for up to WEIGHT[owner] cycles, or until it drops its
// request. It then hands over to the next requester found by searching from the
// slot after it, with no idle cycle in between.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   req[N]          request vector, bit i is requester i
//   gnt[N]          one-hot grant, zero when idle
//   gnt_valid       a grant is active
//   gnt_id          index of the current owner, 0 when idle
//   credit          remaining extra cycles of the owner's quantum
//   rotate          one-cycle pulse on the cycle after the owner releases
module weighted_rr_scheduler #(
    parameter int unsigned      N            = 4,
    parameter int unsigned      WW           = 4,
    parameter logic [WW-1:0]    WEIGHT [N]   = '{default: WW'(1)},
    parameter int unsigned      IDW          = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id,
    output logic [WW-1:0]  credit,
    output logic           rotate
);

    // Elaboration guard on the parameter range
    generate
        if (N < 2 || N > 16 || WW < 1) begin : g_bad_param
            $error("weighted_rr_scheduler: illegal parameters N=%0d WW=%0d", N, WW);
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // (base + off) mod N; both operands are below N, so one subtraction is enough
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                                input int unsigned    off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= N) begin
            s = s - N;
        end
        return IDW'(s);
    endfunction

    // Quantum minus one; a zero weight still gets a single cycle
    function automatic logic [WW-1:0] quantum_m1(input logic [WW-1:0] w);
        return (w == '0) ? '0 : w - WW'(1);
    endfunction

    state_t         r_state;
    logic [IDW-1:0] r_ptr;
    logic [N-1:0]   r_gnt;
    logic           r_gnt_valid;
    logic [IDW-1:0] r_gnt_id;
    logic [WW-1:0]  r_credit;
    logic           r_rotate;

    state_t         w_state_nxt;
    logic [IDW-1:0] w_ptr_nxt;
    logic [N-1:0]   w_gnt_nxt;
    logic           w_gnt_valid_nxt;
    logic [IDW-1:0] w_gnt_id_nxt;
    logic [WW-1:0]  w_credit_nxt;
    logic           w_rotate_nxt;

    logic           w_release;
    logic [IDW-1:0] w_base;
    logic           w_sel_hit;
    logic [IDW-1:0] w_sel;

    // The owner lets go when its request drops or its quantum is used up
    assign w_release = (r_state == ST_GRANT) && (!req[r_gnt_id] || (r_credit == '0));

    // On release the search starts one past the owner, in the same edge
    assign w_base = w_release ? wrap_add(r_gnt_id, 1) : r_ptr;

    // First requester at or after w_base, wrapping modulo N
    always_comb begin
        w_sel_hit = 1'b0;
        w_sel     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!w_sel_hit && req[wrap_add(w_base, i)]) begin
                w_sel_hit = 1'b1;
                w_sel     = wrap_add(w_base, i);
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_gnt_nxt       = r_gnt;
        w_gnt_valid_nxt = r_gnt_valid;
        w_gnt_id_nxt    = r_gnt_id;
        w_credit_nxt    = r_credit;
        w_rotate_nxt    = 1'b0;

        if (r_state == ST_GRANT && !w_release) begin
            w_credit_nxt = r_credit - WW'(1);
        end else begin
            if (w_release) begin
                w_ptr_nxt    = w_base;
                w_rotate_nxt = 1'b1;
            end
            if (w_sel_hit) begin
                w_state_nxt     = ST_GRANT;
                w_gnt_nxt       = N'(1) << w_sel;
                w_gnt_valid_nxt = 1'b1;
                w_gnt_id_nxt    = w_sel;
                w_credit_nxt    = quantum_m1(WEIGHT[w_sel]);
            end else begin
                w_state_nxt     = ST_IDLE;
                w_gnt_nxt       = '0;
                w_gnt_valid_nxt = 1'b0;
                w_gnt_id_nxt    = '0;
                w_credit_nxt    = '0;
            end
        end
    end

    // State and output registers; reset drops any grant without a rotate pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_gnt_id    <= '0;
            r_credit    <= '0;
            r_rotate    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_gnt_id    <= w_gnt_id_nxt;
            r_credit    <= w_credit_nxt;
            r_rotate    <= w_rotate_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_valid = r_gnt_valid;
    assign gnt_id    = r_gnt_id;
    assign credit    = r_credit;
    assign rotate    = r_rotate;

endmodule

// File: tb/tb_weighted_rr_scheduler.sv
// Bench for weighted_rr_scheduler.
// u_dut uses weights {1,2,3,4}. u_dut_w0 uses weights {0,2,3,4} for the
// zero-weight case. Each stimulus step queues the outputs expected after the
// next rising edge. A monitor pops one entry per cycle and compares it.
module tb_weighted_rr_scheduler;

    typedef struct packed {
        logic       dut;
        logic [3:0] gnt;
        logic       valid;
        logic [1:0] id;
        logic [3:0] cr;
        logic       rot;
        int         tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req_a = '0;
    logic [3:0] req_b = '0;

    logic [3:0] gnt_a, gnt_b;
    logic       valid_a, valid_b;
    logic [1:0] id_a, id_b;
    logic [3:0] cr_a, cr_b;
    logic       rot_a, rot_b;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   tag_cnt = 0;

    always #5 clk = ~clk;

    weighted_rr_scheduler #(
        .N(4), .WW(4), .WEIGHT('{4'd1, 4'd2, 4'd3, 4'd4})
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req_a),
        .gnt(gnt_a), .gnt_valid(valid_a), .gnt_id(id_a),
        .credit(cr_a), .rotate(rot_a)
    );

    weighted_rr_scheduler #(
        .N(4), .WW(4), .WEIGHT('{4'd0, 4'd2, 4'd3, 4'd4})
    ) u_dut_w0 (
        .clk(clk), .rst_n(rst_n), .req(req_b),
        .gnt(gnt_b), .gnt_valid(valid_b), .gnt_id(id_b),
        .credit(cr_b), .rotate(rot_b)
    );

    // Drive one cycle of stimulus. id = -1 means idle is expected.
    task automatic step(input logic d, input logic rst, input logic [3:0] r,
                        input int id, input int cr, input logic rot);
        exp_t e;
        @(negedge clk);
        rst_n = rst;
        if (d) begin
            req_b = r;
            req_a = '0;
        end else begin
            req_a = r;
            req_b = '0;
        end
        e.dut   = d;
        e.valid = (id >= 0);
        e.id    = (id >= 0) ? 2'(id) : 2'd0;
        e.gnt   = (id >= 0) ? 4'(1 << id) : 4'd0;
        e.cr    = 4'(cr);
        e.rot   = rot;
        e.tag   = tag_cnt;
        tag_cnt++;
        exp_q.push_back(e);
    endtask

    // One-hot grant, and gnt_valid and gnt_id consistent with gnt
    task automatic check_inv(input int dut, input int tag, input logic [3:0] g,
                             input logic v, input logic [1:0] id);
        logic ok;
        logic [3:0] g_id;
        g_id = 4'(1 << id);
        ok = $onehot0(g) && (v == (g != 4'd0)) && ((g == 4'd0) ? (id == 2'd0) : (g == g_id));
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL invariant step%0d dut%0d: got gnt=%b valid=%b id=%0d, required one-hot gnt matching id",
                     tag, dut, g, v, id);
        end
    endtask

    // Monitor: sample 1 time unit after each rising edge
    initial begin
        exp_t e;
        logic [11:0] act;
        logic [11:0] want;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_inv(0, e.tag, gnt_a, valid_a, id_a);
                check_inv(1, e.tag, gnt_b, valid_b, id_b);
                act  = e.dut ? {gnt_b, valid_b, id_b, cr_b, rot_b}
                             : {gnt_a, valid_a, id_a, cr_a, rot_a};
                want = {e.gnt, e.valid, e.id, e.cr, e.rot};
                checks++;
                if (act !== want) begin
                    failures++;
                    $display("FAIL outputs step%0d dut%0d: got gnt=%b v=%b id=%0d cr=%0d rot=%b, want gnt=%b v=%b id=%0d cr=%0d rot=%b",
                             e.tag, e.dut, act[11:8], act[7], act[6:5], act[4:1], act[0],
                             e.gnt, e.valid, e.id, e.cr, e.rot);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // All requesting from reset release: 0 x1, 1 x2, 2 x3, 3 x4, then 0
        step(0, 0, 4'b1111, -1, 0, 0);
        step(0, 0, 4'b1111, -1, 0, 0);
        step(0, 1, 4'b1111, 0, 0, 0);
        step(0, 1, 4'b1111, 1, 1, 1);
        step(0, 1, 4'b1111, 1, 0, 0);
        step(0, 1, 4'b1111, 2, 2, 1);
        step(0, 1, 4'b1111, 2, 1, 0);
        step(0, 1, 4'b1111, 2, 0, 0);
        step(0, 1, 4'b1111, 3, 3, 1);
        step(0, 1, 4'b1111, 3, 2, 0);
        step(0, 1, 4'b1111, 3, 1, 0);
        step(0, 1, 4'b1111, 3, 0, 0);
        step(0, 1, 4'b1111, 0, 0, 1);
        step(0, 1, 4'b1111, 1, 1, 1);
        // Owner 1 with credit 1 drops its request; 3 takes over at once
        step(0, 1, 4'b1000, 3, 3, 1);
        step(0, 1, 4'b1000, 3, 2, 0);
        // Reset while 3 holds; pointer back to 0, so 0 wins over 3
        step(0, 0, 4'b1001, -1, 0, 0);
        step(0, 1, 4'b1001, 0, 0, 0);
        step(0, 1, 4'b1001, 3, 3, 1);
        // Sole requester 2: continuous grant, credit 2,1,0, rotate every 3 cycles
        step(0, 0, 4'b0100, -1, 0, 0);
        step(0, 1, 4'b0100, 2, 2, 0);
        step(0, 1, 4'b0100, 2, 1, 0);
        step(0, 1, 4'b0100, 2, 0, 0);
        step(0, 1, 4'b0100, 2, 2, 1);
        step(0, 1, 4'b0100, 2, 1, 0);
        step(0, 1, 4'b0100, 2, 0, 0);
        step(0, 1, 4'b0100, 2, 2, 1);
        // Request dropped: release into idle with a rotate pulse
        step(0, 1, 4'b0000, -1, 0, 1);
        step(0, 1, 4'b0000, -1, 0, 0);
        // No requests from reset: stays idle
        step(0, 0, 4'b0000, -1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 4'b0000, -1, 0, 0);
        end
        // Zero weight on requester 0: credit 0 and rotate every cycle
        step(1, 0, 4'b0001, -1, 0, 0);
        step(1, 1, 4'b0001, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 4'b0001, 0, 0, 1);
        end
        // Drain the scoreboard, bounded
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
